// File: rtl/updown_limit_counter_pkg.sv
// -----------------------------------------------------------------------------
// updown_limit_counter_pkg
//   Shared definitions for the up/down limit counter slice.
//   - DEFAULT_WIDTH : default bit width of count, limit and count_to.
//   - req_e         : decoded count request (hold / increment / decrement).
//   - decode_req()  : turns the raw inc/dec strobes into a req_e. Simultaneous
//                     inc and dec cancel out and decode to a hold.
// -----------------------------------------------------------------------------
package updown_limit_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    REQ_HOLD = 2'd0,
    REQ_INC  = 2'd1,
    REQ_DEC  = 2'd2
  } req_e;

  function automatic req_e decode_req(input logic inc, input logic dec);
    req_e r;
    r = REQ_HOLD;
    if (inc && !dec) r = REQ_INC;
    else if (dec && !inc) r = REQ_DEC;
    return r;
  endfunction

endpackage

// File: rtl/updown_limit_counter_if.sv
// -----------------------------------------------------------------------------
// updown_limit_counter_if
//   Request/status bundle of the up/down limit counter.
//   Requests : count_to, count_inc, count_dec, load_en
//   Status   : count_value, flag_count_max, flag_count_min
//   master modport drives requests and observes status; slave is the counter.
// -----------------------------------------------------------------------------
interface updown_limit_counter_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] count_to;
  logic             count_inc;
  logic             count_dec;
  logic             load_en;
  logic [WIDTH-1:0] count_value;
  logic             flag_count_max;
  logic             flag_count_min;

  modport master (
    output count_to, count_inc, count_dec, load_en,
    input  count_value, flag_count_max, flag_count_min
  );

  modport slave (
    input  count_to, count_inc, count_dec, load_en,
    output count_value, flag_count_max, flag_count_min
  );

endinterface

// File: rtl/updown_limit_counter_core.sv
// -----------------------------------------------------------------------------
// updown_limit_counter_core
//   Count register with saturating increment/decrement and a clamp input.
//   Ports:
//     clk       : clock, rising edge
//     reset_n   : synchronous reset, active-high; clears the count
//     req       : decoded request (hold / inc / dec)
//     limit     : current upper saturation bound
//     clamp_en  : limit load in progress; overrides req this cycle
//     clamp_val : new limit; count is pulled down to it if above
//     cnt       : current count
// -----------------------------------------------------------------------------
module updown_limit_counter_core
  import updown_limit_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  req_e             req,
  input  logic [WIDTH-1:0] limit,
  input  logic             clamp_en,
  input  logic [WIDTH-1:0] clamp_val,
  output logic [WIDTH-1:0] cnt
);

  // Step up only while strictly below the bound: no wrap, and a count equal
  // to the limit (including limit 0) holds.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] c,
                                               input logic [WIDTH-1:0] lim);
    return (c < lim) ? c + WIDTH'(1) : c;
  endfunction

  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] c);
    return (c != '0) ? c - WIDTH'(1) : c;
  endfunction

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] c,
                                             input logic [WIDTH-1:0] lim);
    return (c > lim) ? lim : c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset_n) begin
      cnt <= '0;
    end else if (clamp_en) begin
      cnt <= clamp(cnt, clamp_val);
    end else begin
      unique case (req)
        REQ_INC: cnt <= sat_inc(cnt, limit);
        REQ_DEC: cnt <= sat_dec(cnt);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/updown_limit_counter.sv
// -----------------------------------------------------------------------------
// updown_limit_counter
//   Saturating up/down counter with a programmable upper limit and terminal
//   flags. Holds the limit register and the flag decode; the count itself
//   lives in updown_limit_counter_core.
//   Ports:
//     clk     : clock, rising edge
//     reset_n : synchronous reset, active-high (count -> 0, limit -> RESET_LIMIT)
//     bus     : slave side of updown_limit_counter_if
//               count_to/load_en load a new limit (and clamp the count),
//               count_inc/count_dec step the count, count_value and the
//               max/min flags are combinational views of the registers.
// -----------------------------------------------------------------------------
module updown_limit_counter
  import updown_limit_counter_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_LIMIT = WIDTH'((2 ** WIDTH) - 1)
) (
  input logic                  clk,
  input logic                  reset_n,
  updown_limit_counter_if.slave bus
);

  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] cnt;
  req_e             req;

  // A limit load takes the whole cycle: inc/dec are dropped, not deferred.
  assign req = decode_req(bus.count_inc, bus.count_dec);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      limit <= RESET_LIMIT;
    end else if (bus.load_en) begin
      limit <= bus.count_to;
    end
  end

  updown_limit_counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .limit     (limit),
    .clamp_en  (bus.load_en),
    .clamp_val (bus.count_to),
    .cnt       (cnt)
  );

  // Decoded straight from the registers so flags track count_value exactly.
  // With limit 0 both flags are set together while the count sits at 0.
  assign bus.count_value    = cnt;
  assign bus.flag_count_max = (cnt == limit);
  assign bus.flag_count_min = (cnt == '0);

endmodule

// File: tb/tb_updown_limit_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_limit_counter
//   Directed scenarios followed by random traffic, all checked against a
//   behavioural model of the counter (plain integer min/max arithmetic).
// -----------------------------------------------------------------------------
module tb_updown_limit_counter;

  localparam int WIDTH = 4;
  localparam int RLIM  = 15;

  logic clk;
  logic reset_n;

  updown_limit_counter_if #(.WIDTH(WIDTH)) bus ();

  updown_limit_counter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference state
  int m_cnt;
  int m_lim;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Apply one cycle of inputs, advance the model, check all outputs.
  task automatic step(input bit rst, input bit inc, input bit dec,
                      input bit ld, input int to, input string tag);
    @(negedge clk);
    reset_n       = rst;
    bus.count_inc = inc;
    bus.count_dec = dec;
    bus.load_en   = ld;
    bus.count_to  = to[WIDTH-1:0];
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
      m_lim = RLIM;
    end else if (ld) begin
      m_lim = to;
      m_cnt = imin(m_cnt, to);
    end else if (inc && !dec) begin
      m_cnt = imin(m_cnt + 1, m_lim);
    end else if (dec && !inc) begin
      m_cnt = imax(m_cnt - 1, 0);
    end
    #1;
    chk({tag, ".count"}, int'(bus.count_value), m_cnt);
    chk({tag, ".max"}, int'(bus.flag_count_max), int'(m_cnt == m_lim));
    chk({tag, ".min"}, int'(bus.flag_count_min), int'(m_cnt == 0));
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    m_cnt         = 0;
    m_lim         = RLIM;
    reset_n       = 1'b1;
    bus.count_inc = 1'b0;
    bus.count_dec = 1'b0;
    bus.load_en   = 1'b0;
    bus.count_to  = '0;

    // Reset state
    step(1, 0, 0, 0, 0, "reset");
    step(0, 0, 0, 0, 0, "post_reset");
    chk("reset_cnt_const", int'(bus.count_value), 0);
    chk("reset_min_const", int'(bus.flag_count_min), 1);
    chk("reset_max_const", int'(bus.flag_count_max), 0);

    // Count up to saturation at the reset limit of 15
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, "up");
    chk("up_sat_const", int'(bus.count_value), 15);
    chk("up_max_const", int'(bus.flag_count_max), 1);

    // Count down to saturation at 0
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0, "down");
    chk("down_sat_const", int'(bus.count_value), 0);

    // Simultaneous inc/dec at 7
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, "to7");
    step(0, 1, 1, 0, 0, "both");
    chk("both_const", int'(bus.count_value), 7);

    // Limit load with clamp: 12 -> limit 9
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, "to12");
    step(0, 0, 0, 1, 9, "clamp");
    chk("clamp_const", int'(bus.count_value), 9);
    chk("clamp_max_const", int'(bus.flag_count_max), 1);
    step(0, 1, 0, 0, 0, "clamp_inc");

    // Load priority over inc at cnt 2, limit 5
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, "to2");
    step(0, 1, 0, 1, 5, "ld_prio");
    chk("ld_prio_const", int'(bus.count_value), 2);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, "to_lim5");

    // Mid-count reset restores limit 15
    step(1, 1, 0, 0, 0, "mid_reset");
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, "after_reset");

    // Limit 0: both flags, inc/dec hold
    step(0, 0, 0, 1, 0, "lim0");
    step(0, 1, 0, 0, 0, "lim0_inc");
    step(0, 0, 1, 0, 0, "lim0_dec");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit r, a, b, l;
      int t;
      r = ($urandom_range(0, 39) == 0);
      l = ($urandom_range(0, 7) == 0);
      a = $urandom_range(0, 1);
      b = $urandom_range(0, 1);
      t = $urandom_range(0, RLIM);
      step(r, a, b, l, t, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
